// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  aes_pkg
//  Shared Rijndael types and the ShiftRows row-offset helper.
//  Revision: 1.0
// ============================================================================
package aes_pkg;

  localparam int AES_NB_MAX = 8;

  typedef logic [7:0] byte_t;

  // Rijndael row rotation amount C_r; the 256-bit block uses a wider spread.
  function automatic int shift_off(input int nb, input int row);
    if (nb == 8 && row >= 2) return row + 1;
    return row;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_shift_stage.sv
`default_nettype none
// ============================================================================
//  aes_shift_stage
//  One valid/ready register slice with a data-width parameter.
//  Revision: 1.0
// ============================================================================
module aes_shift_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  assign in_ready = !r_valid || out_ready;

  // Data only loads with a real beat, so a bubble never clobbers held data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (in_ready) begin
      r_valid <= in_valid;
      if (in_valid) r_data <= in_data;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/aes_shift_pipe.sv
`default_nettype none
// ============================================================================
//  aes_shift_pipe
//  Pipelined ShiftRows / InvShiftRows with per-beat direction and tag sideband.
//  Revision: 1.0
// ============================================================================
module aes_shift_pipe
  import aes_pkg::*;
#(
  parameter int NB     = 4,
  parameter int STAGES = 1,
  parameter int TAG_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_inv,
  input  logic [TAG_W-1:0]    in_tag,
  input  byte_t [4*NB-1:0]    in_state,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [TAG_W-1:0]    out_tag,
  output byte_t [4*NB-1:0]    out_state
);

  localparam int c_nbytes = 4 * NB;
  localparam int c_data_w = TAG_W + 8 * c_nbytes;

  generate
    if ((NB != 4 && NB != 6 && NB != 8) || NB > AES_NB_MAX) begin : g_bad_nb
      $error("aes_shift_pipe: NB must be 4, 6 or 8");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("aes_shift_pipe: STAGES must be 1..4");
    end
  endgenerate

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  byte_t [c_nbytes-1:0] w_perm;

  generate
    for (genvar c = 0; c < NB; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
        localparam int c_src_f = (c + shift_off(NB, r)) % NB;
        localparam int c_src_i = (c - shift_off(NB, r) + NB) % NB;
        assign w_perm[r + 4*c] = in_inv ? in_state[r + 4*c_src_i]
                                        : in_state[r + 4*c_src_f];
      end
    end
  endgenerate

  logic                w_valid [STAGES+1];
  logic                w_ready [STAGES+1];
  logic [c_data_w-1:0] w_data  [STAGES+1];

  assign w_valid[0]      = in_valid;
  assign w_data[0]       = {in_tag, w_perm};
  assign w_ready[STAGES] = out_ready;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      aes_shift_stage #(
        .W(c_data_w)
      ) u_stage (
        .clk      (clk),
        .rst_n    (w_rst_n),
        .in_valid (w_valid[k]),
        .in_ready (w_ready[k]),
        .in_data  (w_data[k]),
        .out_valid(w_valid[k+1]),
        .out_ready(w_ready[k+1]),
        .out_data (w_data[k+1])
      );
    end
  endgenerate

  // Hold off upstream until the internal reset has released.
  assign in_ready             = w_ready[0] && w_rst_n;
  assign out_valid            = w_valid[STAGES];
  assign {out_tag, out_state} = w_data[STAGES];

endmodule
`default_nettype wire

// File: tb/tb_aes_shift_pipe.sv
`default_nettype none
// ============================================================================
//  tb_aes_shift_pipe
//  Scoreboard bench: NB=4/STAGES=3, NB=6/STAGES=2, NB=8/STAGES=1 instances.
//  Revision: 1.0
// ============================================================================
module tb_aes_shift_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [3:0]   tag;
    logic [255:0] st;
    logic [31:0]  cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  logic         a_in_valid = 0, a_in_ready, a_in_inv = 0, a_out_valid, a_out_ready = 0;
  logic [3:0]   a_in_tag = 0, a_out_tag;
  logic [127:0] a_in_state = 0, a_out_state, a_last;
  logic         b_in_valid = 0, b_in_ready, b_in_inv = 0, b_out_valid, b_out_ready = 0;
  logic [3:0]   b_in_tag = 0, b_out_tag;
  logic [191:0] b_in_state = 0, b_out_state;
  logic [255:0] b_x = 0;
  logic         c_in_valid = 0, c_in_ready, c_in_inv = 0, c_out_valid, c_out_ready = 0;
  logic [3:0]   c_in_tag = 0, c_out_tag;
  logic [255:0] c_in_state = 0, c_out_state, c_last, c_x = 0;

  int a_n_in = 0, b_n_in = 0, c_n_in = 0;
  bit lat_chk = 0;

  aes_shift_pipe #(.NB(4), .STAGES(3), .TAG_W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_inv(a_in_inv), .in_tag(a_in_tag), .in_state(a_in_state),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_tag(a_out_tag),
    .out_state(a_out_state));

  aes_shift_pipe #(.NB(6), .STAGES(2), .TAG_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_inv(b_in_inv), .in_tag(b_in_tag), .in_state(b_in_state),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_tag(b_out_tag),
    .out_state(b_out_state));

  aes_shift_pipe #(.NB(8), .STAGES(1), .TAG_W(4)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_inv(c_in_inv), .in_tag(c_in_tag), .in_state(c_in_state),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_tag(c_out_tag),
    .out_state(c_out_state));

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Reference: each row is a byte list rotated left (fwd) or right (inv) by its offset.
  function automatic logic [255:0] ref_shift(input int nb, input bit inv, input logic [255:0] s);
    logic [255:0] o = '0;
    int           off[4];
    logic [7:0]   row[$];
    if (nb == 8) off = '{0, 1, 3, 4};
    else         off = '{0, 1, 2, 3};
    for (int r = 0; r < 4; r++) begin
      row.delete();
      for (int c = 0; c < nb; c++) row.push_back(s[8*(r+4*c) +: 8]);
      repeat (off[r]) begin
        if (!inv) row.push_back(row.pop_front());
        else      row.push_front(row.pop_back());
      end
      for (int c = 0; c < nb; c++) o[8*(r+4*c) +: 8] = row[c];
    end
    return o;
  endfunction

  // Literals below are written in spec order (byte 0 first); this puts byte 0 at the LSB.
  function automatic logic [127:0] rev16(input logic [127:0] v);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = v[8*(15-i) +: 8];
    return o;
  endfunction

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor A: pushes on accepted input, pops on accepted output, checks stall hold.
  bit           a_stall = 0;
  logic [131:0] a_hold = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (a_in_valid && a_in_ready) begin
        e.tag = a_in_tag;
        e.st  = ref_shift(4, a_in_inv, {128'b0, a_in_state});
        e.cyc = cyc;
        qa.push_back(e);
        a_n_in++;
      end
      if (a_stall) begin
        chk("a_stall_valid", a_out_valid, 1);
        chk("a_stall_hold", {a_out_tag, a_out_state}, a_hold);
      end
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) fail("a_unexpected_beat");
        else begin
          e = qa.pop_front();
          chk("a_state", a_out_state, e.st);
          chk("a_tag", a_out_tag, e.tag);
          if (lat_chk) chk("a_latency", 32'(cyc) - e.cyc, 3);
          a_last = a_out_state;
        end
      end
      a_stall = a_out_valid && !a_out_ready;
      a_hold  = {a_out_tag, a_out_state};
    end else begin
      a_stall = 0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (b_in_valid && b_in_ready) begin
        e.tag = b_in_tag;
        e.st  = b_in_inv ? b_x : ref_shift(6, 1'b0, {64'b0, b_in_state});
        e.cyc = cyc;
        qb.push_back(e);
        b_n_in++;
      end
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) fail("b_unexpected_beat");
        else begin
          e = qb.pop_front();
          chk("b_state", b_out_state, e.st);
          chk("b_tag", b_out_tag, e.tag);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (c_in_valid && c_in_ready) begin
        e.tag = c_in_tag;
        e.st  = c_in_inv ? c_x : ref_shift(8, 1'b0, c_in_state);
        e.cyc = cyc;
        qc.push_back(e);
        c_n_in++;
      end
      if (c_out_valid && c_out_ready) begin
        if (qc.size() == 0) fail("c_unexpected_beat");
        else begin
          e = qc.pop_front();
          chk("c_state", c_out_state, e.st);
          chk("c_tag", c_out_tag, e.tag);
          c_last = c_out_state;
        end
      end
    end
  end

  task automatic send_a(input logic [127:0] st, input bit inv, input logic [3:0] tag);
    int g = 0;
    @(posedge clk); #1;
    a_in_valid = 1; a_in_inv = inv; a_in_tag = tag; a_in_state = st;
    do begin
      @(negedge clk);
      g++;
    end while (!(a_in_valid && a_in_ready) && g < 50);
    if (g >= 50) fail("a_accept_timeout");
  endtask

  task automatic idle_a();
    @(posedge clk); #1;
    a_in_valid = 0;
  endtask

  task automatic drain_a();
    int g = 0;
    while (qa.size() != 0 && g < 500) begin
      @(negedge clk); #1;
      g++;
    end
    if (qa.size() != 0) fail("a_drain_timeout");
  endtask

  task automatic rand_a(input int n);
    int g = 0;
    int target = a_n_in + n;
    while (a_n_in < target && g < 20000) begin
      @(posedge clk); #1;
      a_in_valid  = $urandom_range(0, 1);
      a_in_inv    = $urandom_range(0, 1);
      a_in_tag    = 4'($urandom);
      a_in_state  = rnd128();
      a_out_ready = $urandom_range(0, 1);
      g++;
    end
    if (g >= 20000) fail("a_random_timeout");
    @(posedge clk); #1;
    a_in_valid = 0; a_out_ready = 1;
    drain_a();
  endtask

  task automatic rand_b(input int n);
    int g = 0;
    logic [255:0] t;
    while (b_n_in < n && g < 20000) begin
      @(posedge clk); #1;
      b_x         = rnd256() & {64'b0, {192{1'b1}}};
      t           = ref_shift(6, 1'b0, b_x);
      b_in_inv    = $urandom_range(0, 1);
      b_in_state  = b_in_inv ? t[191:0] : b_x[191:0];
      b_in_tag    = 4'($urandom);
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_out_ready = $urandom_range(0, 1);
      g++;
    end
    if (g >= 20000) fail("b_random_timeout");
    @(posedge clk); #1;
    b_in_valid = 0; b_out_ready = 1;
    g = 0;
    while (qb.size() != 0 && g < 500) begin
      @(negedge clk); #1;
      g++;
    end
    if (qb.size() != 0) fail("b_drain_timeout");
  endtask

  task automatic rand_c(input int n);
    int g = 0;
    int target = c_n_in + n;
    logic [255:0] t;
    while (c_n_in < target && g < 20000) begin
      @(posedge clk); #1;
      c_x         = rnd256();
      t           = ref_shift(8, 1'b0, c_x);
      c_in_inv    = $urandom_range(0, 1);
      c_in_state  = c_in_inv ? t : c_x;
      c_in_tag    = 4'($urandom);
      c_in_valid  = ($urandom_range(0, 3) != 0);
      c_out_ready = $urandom_range(0, 1);
      g++;
    end
    if (g >= 20000) fail("c_random_timeout");
    @(posedge clk); #1;
    c_in_valid = 0; c_out_ready = 1;
    g = 0;
    while (qc.size() != 0 && g < 500) begin
      @(negedge clk); #1;
      g++;
    end
    if (qc.size() != 0) fail("c_drain_timeout");
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [127:0] seq16, lit_fwd, fips_in, fips_out;
    logic [255:0] seq32;
    int g;
    for (int i = 0; i < 16; i++) seq16[8*i +: 8] = 8'(i);
    for (int i = 0; i < 32; i++) seq32[8*i +: 8] = 8'(i);
    lit_fwd  = rev16(128'h00050a0f04090e03080d02070c01060b);
    fips_in  = rev16(128'hd42711aee0bf98f1b8b45de51e415230);
    fips_out = rev16(128'hd4bf5d30e0b452aeb84111f11e2798e5);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_state", a_out_state, 0);
    chk("rst_out_tag", a_out_tag, 0);
    chk("rst_c_out_valid", c_out_valid, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rel_in_ready", a_in_ready, 1);
    chk("rel_out_valid", a_out_valid, 0);

    a_out_ready = 1;
    lat_chk = 1;
    send_a(seq16, 1'b0, 4'h1);
    idle_a(); drain_a();
    chk("nb4_fwd_seq", a_last, lit_fwd);
    send_a(fips_in, 1'b0, 4'h2);
    idle_a(); drain_a();
    chk("nb4_fips_round1", a_last, fips_out);
    send_a(lit_fwd, 1'b1, 4'h3);
    idle_a(); drain_a();
    chk("nb4_inv_seq", a_last, seq16);
    for (int i = 0; i < 16; i++) send_a(rnd128(), i[0], 4'(i));
    idle_a(); drain_a();
    lat_chk = 0;

    c_out_ready = 1;
    @(posedge clk); #1;
    c_in_valid = 1; c_in_inv = 0; c_in_state = seq32; c_in_tag = 4'h5;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!(c_in_valid && c_in_ready) && g < 50);
    if (g >= 50) fail("c_accept_timeout");
    @(posedge clk); #1;
    c_in_valid = 0;
    g = 0;
    while (qc.size() != 0 && g < 50) begin
      @(negedge clk); #1;
      g++;
    end
    if (qc.size() != 0) fail("c_drain_timeout");
    chk("nb8_fwd_first4", c_last[31:0], 32'h130e0500);

    fork
      rand_a(400);
      rand_b(1000);
      rand_c(1000);
    join

    // Fill A completely under backpressure, then reset it mid-stream.
    a_out_ready = 0;
    @(posedge clk); #1;
    a_in_valid = 1; a_in_state = rnd128();
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (a_in_ready && g < 50);
    if (g >= 50) fail("a_fill_timeout");
    chk("full_out_valid", a_out_valid, 1);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    qa.delete();
    chk("async_rst_out_valid", a_out_valid, 0);
    chk("async_rst_out_state", a_out_state, 0);
    chk("async_rst_out_tag", a_out_tag, 0);
    a_in_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rel2_in_ready", a_in_ready, 1);
    chk("rel2_out_valid", a_out_valid, 0);
    chk("rel2_out_state", a_out_state, 0);
    a_out_ready = 1;
    lat_chk = 1;
    send_a(fips_in, 1'b0, 4'h9);
    idle_a(); drain_a();
    chk("post_rst_fips", a_last, fips_out);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
